// File: rtl/spi_register_peripheral_if.sv
// SPI serial lines between controller and register peripheral.
// Ports: cs_b (active-low select), pico (to peripheral), poci (to controller).
interface spi_register_peripheral_if;
  logic cs_b;
  logic pico;
  logic poci;

  modport master (
    output cs_b,
    output pico,
    input  poci
  );

  modport slave (
    input  cs_b,
    input  pico,
    output poci
  );
endinterface

// File: rtl/spi_register_peripheral.sv
// SPI responder owning a NUM_REGS x 32b configuration register file.
// Ports: spi_clk/spi_reset (async, active-high); spi (slave: cs_b, pico,
// poci); regs (flat, reg k = regs[32k+:32]); reg_wr_strb (per-reg commit
// pulse); busy; frame_count (completed frames); frame_err (abort/reject).
// Option: define SPI_PERIPH_PARITY_EN to require even parity on the header.
module spi_register_peripheral #(
  parameter int NUM_REGS = 16
) (
  input  logic                     spi_clk,
  input  logic                     spi_reset,
  spi_register_peripheral_if.slave spi,
  output logic [NUM_REGS*32-1:0]   regs,
  output logic [NUM_REGS-1:0]      reg_wr_strb,
  output logic                     busy,
  output logic [15:0]              frame_count,
  output logic                     frame_err
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DONE
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [4:0]          bit_cnt;
  logic [30:0]         sh_in;
  logic [31:0]         word_full;
  logic [31:0]         shadow;
  logic [31:0]         rf [NUM_REGS];
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_nx;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [7:0]          hdr_n;
  logic [7:0]          n_words;
  logic [7:0]          k;
  logic                wr;
  logic                last_bit;
  logic                parity_bad;
  logic                load;
  logic                step;
  logic                commit;
  logic                err;
  logic                fin;

  // Bit 31 is never stored; it is taken straight from pico at the word edge.
  assign word_full = {spi.pico, sh_in};
  assign last_bit  = (bit_cnt == 5'd31);
  assign hdr_n     = word_full[15:8];
  assign hdr_addr  = word_full[ADDR_W:1];
  assign addr_nx   = addr + ADDR_W'(1);
  assign busy      = (state != IDLE);

`ifdef SPI_PERIPH_PARITY_EN
  assign parity_bad = ^word_full;
`else
  assign parity_bad = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[32*g +: 32] = rf[g];
  end

  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!spi.cs_b) state_n = HEADER;
      end
      HEADER: begin
        if (spi.cs_b) begin
          state_n = IDLE;
          err     = 1'b1;
        end else if (last_bit) begin
          if (parity_bad) begin
            state_n = DONE;
            err     = 1'b1;
          end else if (hdr_n == 8'd0) begin
            state_n = DONE;
            fin     = 1'b1;
          end else begin
            state_n = DATA;
            load    = 1'b1;
          end
        end
      end
      DATA: begin
        if (spi.cs_b) begin
          state_n = IDLE;
          err     = 1'b1;
        end else if (last_bit) begin
          step   = 1'b1;
          commit = wr;
          if (k == n_words - 8'd1) begin
            state_n = DONE;
            fin     = 1'b1;
          end
        end
      end
      DONE: begin
        if (spi.cs_b) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      bit_cnt     <= '0;
      sh_in       <= '0;
      shadow      <= '0;
      addr        <= '0;
      n_words     <= '0;
      k           <= '0;
      wr          <= 1'b0;
      spi.poci    <= 1'b0;
      reg_wr_strb <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      reg_wr_strb <= '0;
      frame_err   <= err;
      spi.poci    <= 1'b0;
      if (fin) frame_count <= frame_count + 16'd1;
      if (spi.cs_b) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 5'd1;
        if (!last_bit) sh_in[bit_cnt] <= spi.pico;
      end
      if (state == DATA && !spi.cs_b) spi.poci <= shadow[bit_cnt];
      if (load) begin
        addr    <= hdr_addr;
        wr      <= word_full[0];
        n_words <= hdr_n;
        k       <= '0;
        shadow  <= rf[hdr_addr];
      end
      if (step) begin
        k    <= k + 8'd1;
        addr <= addr_nx;
        // Next shadow must see this word's commit if it targets the same reg.
        if (commit && addr_nx == addr) shadow <= word_full;
        else                           shadow <= rf[addr_nx];
        if (commit) begin
          rf[addr]          <= word_full;
          reg_wr_strb[addr] <= 1'b1;
        end
      end
    end
  end
endmodule
